// File: rtl/mmio_io_hub.sv
// rtl/mmio_io_hub.sv - memory-mapped IO hub: switches, LEDs, 7-seg, blink, debounced buttons, timer
module mmio_io_hub #(
    parameter int N_BTN        = 5,
    parameter int SW_W         = 24,
    parameter int LED_W        = 24,
    parameter int SEG_W        = 24,
    parameter int DEBOUNCE_CYC = 200000,
    parameter int TIMER_W      = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_BTN-1:0]   btn_raw,
    input  logic [SW_W-1:0]    sw_raw,
    input  logic               io_read,
    input  logic               io_write,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               rd_valid,
    output logic [LED_W-1:0]   led_out,
    output logic [SEG_W-1:0]   seg_data,
    output logic               blink_out,
    output logic [N_BTN-1:0]   btn_level
);
    localparam int CW = $clog2(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

    localparam logic [7:0] OFF_SW     = 8'h00;
    localparam logic [7:0] OFF_LEVEL  = 8'h01;
    localparam logic [7:0] OFF_EVT    = 8'h02;
    localparam logic [7:0] OFF_EVT_RC = 8'h03;
    localparam logic [7:0] OFF_LED    = 8'h04;
    localparam logic [7:0] OFF_SEG    = 8'h05;
    localparam logic [7:0] OFF_BLINK  = 8'h06;
    localparam logic [7:0] OFF_TIMER  = 8'h07;

    logic [N_BTN-1:0]   btn_s1, btn_s2;
    logic [SW_W-1:0]    sw_s1, sw_s2;
    logic [CW-1:0]      db_cnt [N_BTN];
    logic [N_BTN-1:0]   btn_evt;
    logic [TIMER_W-1:0] timer;

    logic               hit, wr_hit, rd_hit;
    logic [7:0]         off;
    logic [N_BTN-1:0]   flip, rise, evt_clr;
    logic [31:0]        rd_mux;
    logic               unused_bits;

    assign hit         = (addr[31:10] == 22'h3FFFFF);
    assign off         = addr[9:2];
    assign wr_hit      = io_write && hit;
    assign rd_hit      = io_read && hit;
    assign unused_bits = ^{addr[1:0], wdata};

    // A channel flips once its synced input has disagreed for DEBOUNCE_CYC edges.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            flip[i] = (btn_s2[i] != btn_level[i]) && (db_cnt[i] == CNT_MAX);
        end
        rise = flip & ~btn_level;
    end

    always_comb begin
        evt_clr = '0;
        if (wr_hit && off == OFF_EVT)
            evt_clr = wdata[N_BTN-1:0];
        if (rd_hit && off == OFF_EVT_RC)
            evt_clr = '1;
    end

    always_comb begin
        rd_mux = 32'h0;
        if (hit) begin
            case (off)
                OFF_SW:     rd_mux = 32'(sw_s2);
                OFF_LEVEL:  rd_mux = 32'(btn_level);
                OFF_EVT,
                OFF_EVT_RC: rd_mux = 32'(btn_evt);
                OFF_LED:    rd_mux = 32'(led_out);
                OFF_SEG:    rd_mux = 32'(seg_data);
                OFF_BLINK:  rd_mux = {31'h0, blink_out};
                OFF_TIMER:  rd_mux = 32'(timer);
                default:    rd_mux = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
            sw_s1  <= sw_raw;
            sw_s2  <= sw_s1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_BTN; i++) db_cnt[i] <= '0;
            btn_level <= '0;
            btn_evt   <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (btn_s2[i] == btn_level[i] || flip[i])
                    db_cnt[i] <= '0;
                else
                    db_cnt[i] <= db_cnt[i] + 1'b1;
            end
            btn_level <= btn_level ^ flip;
            btn_evt   <= (btn_evt & ~evt_clr) | rise;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            led_out   <= '0;
            seg_data  <= '0;
            blink_out <= 1'b0;
            timer     <= '0;
            rdata     <= 32'h0;
            rd_valid  <= 1'b0;
        end else begin
            if (wr_hit && off == OFF_LED)   led_out   <= wdata[LED_W-1:0];
            if (wr_hit && off == OFF_SEG)   seg_data  <= wdata[SEG_W-1:0];
            if (wr_hit && off == OFF_BLINK) blink_out <= wdata[0];
            if (wr_hit && off == OFF_TIMER)
                timer <= wdata[TIMER_W-1:0];
            else
                timer <= timer + 1'b1;
            rd_valid <= io_read;
            if (io_read)
                rdata <= rd_mux;
        end
    end
endmodule

// File: tb/tb_mmio_io_hub.sv
// tb/tb_mmio_io_hub.sv - directed self-checking bench for mmio_io_hub
module tb_mmio_io_hub;
    localparam logic [31:0] A_SW     = 32'hFFFFFC00;
    localparam logic [31:0] A_LEVEL  = 32'hFFFFFC04;
    localparam logic [31:0] A_EVT    = 32'hFFFFFC08;
    localparam logic [31:0] A_EVT_RC = 32'hFFFFFC0C;
    localparam logic [31:0] A_LED    = 32'hFFFFFC10;
    localparam logic [31:0] A_SEG    = 32'hFFFFFC14;
    localparam logic [31:0] A_BLINK  = 32'hFFFFFC18;
    localparam logic [31:0] A_TIMER  = 32'hFFFFFC1C;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  btn_raw = '0;
    logic [23:0] sw_raw = '0;
    logic        io_read = 1'b0;
    logic        io_write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rd_valid;
    logic [23:0] led_out;
    logic [23:0] seg_data;
    logic        blink_out;
    logic [4:0]  btn_level;

    int total = 0;
    int bad = 0;
    logic [31:0] rd;
    logic        vld;

    mmio_io_hub #(
        .N_BTN(5), .SW_W(24), .LED_W(24), .SEG_W(24), .DEBOUNCE_CYC(4), .TIMER_W(32)
    ) dut (
        .clock(clock), .reset(reset), .btn_raw(btn_raw), .sw_raw(sw_raw),
        .io_read(io_read), .io_write(io_write), .addr(addr), .wdata(wdata),
        .rdata(rdata), .rd_valid(rd_valid), .led_out(led_out), .seg_data(seg_data),
        .blink_out(blink_out), .btn_level(btn_level)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; io_write = 1'b1;
        @(negedge clock);
        io_write = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
        addr = a; io_read = 1'b1;
        @(negedge clock);
        io_read = 1'b0;
        d = rdata; v = rd_valid;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        wait_cyc(4);
        check("rst_led", 32'(led_out), 32'h0);
        check("rst_seg", 32'(seg_data), 32'h0);
        check("rst_blink", 32'(blink_out), 32'h0);
        check("rst_level", 32'(btn_level), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_valid", 32'(rd_valid), 32'h0);
        reset = 1'b1;
        @(negedge clock);
        bus_read(A_TIMER, rd, vld);
        check("timer_after_rst", rd, 32'h1);

        // LED write/read, then combined read+write returns pre-write value
        bus_write(A_LED, 32'hDEADBEEF);
        check("led_out", 32'(led_out), 32'h00ADBEEF);
        bus_read(A_LED, rd, vld);
        check("led_rdata", rd, 32'h00ADBEEF);
        check("led_valid", 32'(vld), 32'h1);
        @(negedge clock);
        check("valid_pulse", 32'(rd_valid), 32'h0);
        check("rdata_hold", rdata, 32'h00ADBEEF);
        addr = A_LED; wdata = 32'h00112233; io_read = 1'b1; io_write = 1'b1;
        @(negedge clock);
        io_read = 1'b0; io_write = 1'b0;
        check("rw_rdata_old", rdata, 32'h00ADBEEF);
        check("rw_led_new", 32'(led_out), 32'h00112233);

        bus_write(A_SEG, 32'hCAFE1234);
        bus_read(A_SEG, rd, vld);
        check("seg_rdata", rd, 32'h00FE1234);
        bus_write(A_BLINK, 32'hFFFFFFFF);
        check("blink_out", 32'(blink_out), 32'h1);
        bus_read(A_BLINK, rd, vld);
        check("blink_rdata", rd, 32'h1);

        sw_raw = 24'h123456;
        wait_cyc(2);
        bus_read(A_SW, rd, vld);
        check("sw_rdata", rd, 32'h00123456);

        // Decode: outside window and unmapped offset
        bus_write(32'h00001010, 32'h00777777);
        check("decode_led", 32'(led_out), 32'h00112233);
        bus_read(32'hFFFFFCF0, rd, vld);
        check("unmapped_rdata", rd, 32'h0);
        check("unmapped_valid", 32'(vld), 32'h1);
        bus_read(32'h00001010, rd, vld);
        check("outside_rdata", rd, 32'h0);
        check("outside_valid", 32'(vld), 32'h1);

        // Debounce: 3-cycle glitch rejected, sustained press accepted at edge 6
        btn_raw = 5'b00100;
        wait_cyc(3);
        btn_raw = 5'b00000;
        wait_cyc(8);
        check("glitch_level", 32'(btn_level), 32'h0);
        bus_read(A_EVT, rd, vld);
        check("glitch_evt", rd, 32'h0);
        btn_raw = 5'b00100;
        wait_cyc(5);
        check("press_edge5", 32'(btn_level), 32'h0);
        @(negedge clock);
        check("press_edge6", 32'(btn_level), 32'h4);
        bus_read(A_EVT, rd, vld);
        check("press_evt", rd, 32'h4);

        bus_write(A_EVT, 32'h4);
        bus_read(A_EVT, rd, vld);
        check("rw1c_evt", rd, 32'h0);

        // Read-to-clear with two flags
        btn_raw = 5'b00000;
        wait_cyc(8);
        check("release_level", 32'(btn_level), 32'h0);
        btn_raw = 5'b00101;
        wait_cyc(8);
        bus_read(A_LEVEL, rd, vld);
        check("level_rdata", rd, 32'h5);
        bus_read(A_EVT_RC, rd, vld);
        check("rc_first", rd, 32'h5);
        bus_read(A_EVT_RC, rd, vld);
        check("rc_second", rd, 32'h0);

        // Clear coinciding with a new rising edge: set wins
        btn_raw = 5'b00100;
        wait_cyc(8);
        btn_raw = 5'b00101;
        wait_cyc(5);
        bus_write(A_EVT, 32'h1);
        check("set_vs_clr_level", 32'(btn_level), 32'h5);
        bus_read(A_EVT, rd, vld);
        check("set_wins", rd, 32'h1);
        bus_write(A_EVT, 32'h1);
        bus_read(A_EVT, rd, vld);
        check("clr_after", rd, 32'h0);

        // Timer load and wrap
        bus_write(A_TIMER, 32'hFFFFFFFE);
        bus_read(A_TIMER, rd, vld);
        check("timer_load", rd, 32'hFFFFFFFE);
        @(negedge clock);
        bus_read(A_TIMER, rd, vld);
        check("timer_wrap", rd, 32'h00000000);
        @(negedge clock);
        bus_read(A_TIMER, rd, vld);
        check("timer_count", rd, 32'h00000002);

        // Reset during a read strobe: no rd_valid, state cleared
        addr = A_TIMER; io_read = 1'b1; reset = 1'b0;
        @(negedge clock);
        check("rst_mid_valid", 32'(rd_valid), 32'h0);
        check("rst_mid_led", 32'(led_out), 32'h0);
        check("rst_mid_level", 32'(btn_level), 32'h0);
        io_read = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mmio_io_hub.md
Name: mmio_io_hub

Overview:
Parametrised memory-mapped IO peripheral. It generalises the CPU's IO path: switch input, LED, 7-seg and blink outputs, plus per-button debouncing and press-event latching, which currently sit in separate per-button instances. It sits between the CPU's IORead/IOWrite/ALU_result/Read_data_2 signals and the board pins. It adds sticky button events, read-to-clear behaviour and a loadable free-running timer.

Parameters:
N_BTN, 5, number of button channels (1..32)
SW_W, 24, switch input width (1..32)
LED_W, 24, LED register width (1..32)
SEG_W, 24, 7-seg data register width (1..32)
DEBOUNCE_CYC, 200000, consecutive stable cycles required to accept a button level change (>=2)
TIMER_W, 32, timer width (1..32)

Ports:
clock  in  1  system clock; all state is clocked on the rising edge
reset  in  1  asynchronous active-low reset
btn_raw  in  N_BTN  raw button pins, asynchronous
sw_raw  in  SW_W  raw switch pins, asynchronous
io_read  in  1  single-cycle read strobe
io_write  in  1  single-cycle write strobe
addr  in  32  byte address (ALU_result)
wdata  in  32  write data (Read_data_2)
rdata  out  32  registered read data
rd_valid  out  1  pulses high for 1 cycle when rdata is valid
led_out  out  LED_W  LED register
seg_data  out  SEG_W  7-seg data register
blink_out  out  1  blink enable
btn_level  out  N_BTN  debounced button levels

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0. Synchronisers, debounce counters, stable levels, event flags and timer all cleared.
- Decode: a cycle is a hub access only when addr[31:10]==22'h3FFFFF. Offset = addr[9:2]; addr[1:0] are ignored.
- Register map (word offsets):
  - 0x00 SW (RO): synchronised switches, zero-extended.
  - 0x01 BTN_LEVEL (RO): debounced levels.
  - 0x02 BTN_EVT (RW1C): sticky press flags. A write clears bits where wdata=1.
  - 0x03 BTN_EVT_RC (RO): returns the flags and clears all of them on the read.
  - 0x04 LED (RW).
  - 0x05 SEG (RW).
  - 0x06 BLINK (RW): bit0 only.
  - 0x07 TIMER (RW).
  - All other offsets read 0; writes to them are ignored.
- Width rules: writes keep the low bits of wdata up to the register width. Reads are zero-extended to 32 bits.
- Read latency: io_read sampled at edge k gives rdata and rd_valid=1 after edge k. rdata holds its value until the next read. rd_valid also pulses for an undecoded address, with rdata=0.
- Writes take effect at the sampling edge.
- Simultaneous io_read and io_write to the same register: the write is performed, and rdata returns the pre-write value.
- Synchronisation: btn_raw and sw_raw each pass through 2 flops before use.
- Debounce (per channel, independent):
  - Counter resets to 0 whenever the synced input equals the stable level.
  - Otherwise the counter increments each cycle. When it reaches DEBOUNCE_CYC-1, the stable level flips and the counter resets.
  - A glitch shorter than DEBOUNCE_CYC cycles never changes the level.
  - Counter width is clog2(DEBOUNCE_CYC).
- Events: a rising edge on a stable level (0->1) sets the channel's flag. If a set and a clear (RW1C write or RC read) hit the same bit in the same cycle, the set wins.
- Timer:
  - Increments every cycle and wraps from all-ones to 0.
  - A write loads wdata[TIMER_W-1:0]. Write beats increment in that cycle; the loaded value increments from the next cycle.
  - A read returns the value before that edge.
- Reset asserted mid-debounce or mid-read: all state clears immediately. No rd_valid is produced for an interrupted read.
- Outputs led_out, seg_data, blink_out and btn_level are driven directly from registers, with no combinational path from the inputs.

Test Plan:
(all with DEBOUNCE_CYC=4)
- Reset: reset=0 while the timer runs, then released -> all outputs 0. A read of TIMER 1 cycle after release returns 0 or 1; it is exactly 1 if sampled at the second edge.
- LED write/read: write 0xFFFFFC10 <- 0xDEADBEEF, then read 0xFFFFFC10 -> led_out=24'hADBEEF and rdata=32'h00ADBEEF with rd_valid 1 cycle after the read strobe.
- Debounce: btn_raw[2] high for 3 cycles then low -> btn_level unchanged, BTN_EVT=0. Hold high for 6 cycles -> btn_level[2]=1 at 2+4 cycles after the rise, and BTN_EVT reads 0x4.
- Events:
  - RW1C write of 0x4 -> BTN_EVT reads 0.
  - BTN_EVT_RC read with flags 0x5 -> rdata=0x5, then the next read returns 0.
  - Clear in the same cycle as a new edge -> the flag stays set.
- Timer: write TIMER <- 0xFFFFFFFE -> reads 2 cycles apart show wrap to 0x00000000 and then counting up.
- Decode: write to 0x00001010 -> led_out unchanged. Read of offset 0x3C (inside the window, unmapped) -> rdata=0, rd_valid=1. Read of SW with sw_raw=24'h123456 (after 2 sync cycles) -> 0x00123456.
